// File: rtl/jtag_tap_ctrl.sv
// TAP controller for the s9234 boundary/internal scan wrapper: 16-state TMS FSM,
// instruction register, bypass bit, DR enable decode and the final TDO mux.
module jtag_tap_ctrl #(
  parameter int                 IR_LEN     = 4,
  parameter logic [IR_LEN-1:0]  OP_EXTEST  = IR_LEN'(0),
  parameter logic [IR_LEN-1:0]  OP_SAMPLE  = IR_LEN'(1),
  parameter logic [IR_LEN-1:0]  OP_INTSCAN = IR_LEN'(2),
  parameter logic [IR_LEN-1:0]  OP_BYPASS  = '1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              TMS,
  input  logic              TDI,
  input  logic              TDO_BSR,
  input  logic              TDO_ISR,
  output logic              clockdr,
  output logic              updatedr,
  output logic              shiftdr,
  output logic              clockdr_is,
  output logic              updatedr_is,
  output logic              shiftdr_is,
  output logic              extest,
  output logic              TDO,
  output logic              TDO_EN,
  output logic [3:0]        tap_state,
  output logic [IR_LEN-1:0] ir_out
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_e;

  tap_state_e        state_q, state_d;
  logic [IR_LEN-1:0] ir_sr_q;
  logic              byp_q;
  logic              sel_bsr, sel_isr, sel_byp;
  logic              in_cap_dr, in_sh_dr, in_upd_dr, in_sh_ir;

  always_ff @(posedge CK) begin
    // NOTE: sequential state always uses <= so every flop samples pre-edge values.
    if (RST) state_q <= TLR;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      TLR:    state_d = TMS ? TLR    : RTI;
      RTI:    state_d = TMS ? SEL_DR : RTI;
      SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR: state_d = TMS ? UPD_DR : PA_DR;
      PA_DR:  state_d = TMS ? EX2_DR : PA_DR;
      EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR: state_d = TMS ? SEL_DR : RTI;
      SEL_IR: state_d = TMS ? TLR    : CAP_IR;
      CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR: state_d = TMS ? UPD_IR : PA_IR;
      PA_IR:  state_d = TMS ? EX2_IR : PA_IR;
      EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR: state_d = TMS ? SEL_DR : RTI;
    endcase
  end

  assign in_cap_dr = (state_q == CAP_DR);
  assign in_sh_dr  = (state_q == SH_DR);
  assign in_upd_dr = (state_q == UPD_DR);
  assign in_sh_ir  = (state_q == SH_IR);

  assign sel_bsr = (ir_out == OP_EXTEST) || (ir_out == OP_SAMPLE);
  assign sel_isr = (ir_out == OP_INTSCAN);
  assign sel_byp = !sel_bsr && !sel_isr;

  // Active instruction only moves in UPD_IR, or falls back to BYPASS on entering TLR.
  always_ff @(posedge CK) begin
    if (RST) begin
      ir_sr_q <= '0;
      ir_out  <= OP_BYPASS;
      byp_q   <= 1'b0;
    end else begin
      if (state_q == CAP_IR)  ir_sr_q <= IR_LEN'(1);
      else if (in_sh_ir)      ir_sr_q <= {TDI, ir_sr_q[IR_LEN-1:1]};

      if (state_q == UPD_IR)  ir_out <= ir_sr_q;
      else if (state_d == TLR) ir_out <= OP_BYPASS;

      if (sel_byp && in_cap_dr)     byp_q <= 1'b0;
      else if (sel_byp && in_sh_dr) byp_q <= TDI;
    end
  end

  assign clockdr     = sel_bsr && (in_cap_dr || in_sh_dr);
  assign shiftdr     = sel_bsr && in_sh_dr;
  assign updatedr    = sel_bsr && in_upd_dr;
  assign clockdr_is  = sel_isr && (in_cap_dr || in_sh_dr);
  assign shiftdr_is  = sel_isr && in_sh_dr;
  assign updatedr_is = sel_isr && in_upd_dr;

  assign extest    = (ir_out == OP_EXTEST);
  assign TDO_EN    = in_sh_ir || in_sh_dr;
  assign tap_state = state_q;

  always_comb begin
    TDO = 1'b0;
    if (in_sh_ir)     TDO = ir_sr_q[0];
    else if (in_sh_dr) begin
      if (sel_bsr)      TDO = TDO_BSR;
      else if (sel_isr) TDO = TDO_ISR;
      else              TDO = byp_q;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Self-checking bench for jtag_tap_ctrl: a TMS-table state model plus a TDO
// scoreboard (expected bit queued when a shift bit is driven, popped when sampled).
module tb_jtag_tap_ctrl;

  logic       CK = 1'b0;
  logic       RST, TMS, TDI, TDO_BSR, TDO_ISR;
  logic       clockdr, updatedr, shiftdr, clockdr_is, updatedr_is, shiftdr_is;
  logic       extest, TDO, TDO_EN;
  logic [3:0] tap_state;
  logic [3:0] ir_out;

  jtag_tap_ctrl dut (
    .CK(CK), .RST(RST), .TMS(TMS), .TDI(TDI), .TDO_BSR(TDO_BSR), .TDO_ISR(TDO_ISR),
    .clockdr(clockdr), .updatedr(updatedr), .shiftdr(shiftdr),
    .clockdr_is(clockdr_is), .updatedr_is(updatedr_is), .shiftdr_is(shiftdr_is),
    .extest(extest), .TDO(TDO), .TDO_EN(TDO_EN), .tap_state(tap_state), .ir_out(ir_out)
  );

  always #5 CK = ~CK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    string tag;
    logic  exp;
  } exp_t;
  exp_t sb_q[$];

  logic [3:0] m_state;
  int c_ck, c_sh, c_up, c_ck_is, c_sh_is, c_up_is, c_en;

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic tms);
    case (s)
      4'd0:    return tms ? 4'd0  : 4'd1;
      4'd1:    return tms ? 4'd2  : 4'd1;
      4'd2:    return tms ? 4'd9  : 4'd3;
      4'd3:    return tms ? 4'd5  : 4'd4;
      4'd4:    return tms ? 4'd5  : 4'd4;
      4'd5:    return tms ? 4'd8  : 4'd6;
      4'd6:    return tms ? 4'd7  : 4'd6;
      4'd7:    return tms ? 4'd8  : 4'd4;
      4'd8:    return tms ? 4'd2  : 4'd1;
      4'd9:    return tms ? 4'd0  : 4'd10;
      4'd10:   return tms ? 4'd12 : 4'd11;
      4'd11:   return tms ? 4'd12 : 4'd11;
      4'd12:   return tms ? 4'd15 : 4'd13;
      4'd13:   return tms ? 4'd14 : 4'd13;
      4'd14:   return tms ? 4'd15 : 4'd11;
      default: return tms ? 4'd2  : 4'd1;
    endcase
  endfunction

  task automatic clear_counts();
    c_ck = 0; c_sh = 0; c_up = 0; c_ck_is = 0; c_sh_is = 0; c_up_is = 0; c_en = 0;
  endtask

  // One TCK cycle: apply inputs, observe the cycle at the falling edge, then clock.
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(negedge CK);
    check("tap_state", tap_state, m_state);
    check("tdo_en", TDO_EN, (m_state == 4'd4) || (m_state == 4'd11));
    c_ck    += int'(clockdr);
    c_sh    += int'(shiftdr);
    c_up    += int'(updatedr);
    c_ck_is += int'(clockdr_is);
    c_sh_is += int'(shiftdr_is);
    c_up_is += int'(updatedr_is);
    c_en    += int'(TDO_EN);
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check(e.tag, TDO, e.exp);
    end
    @(posedge CK);
    #1;
    m_state = model_next(m_state, tms);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    TMS = 1'b0;
    @(posedge CK);
    #1;
    RST = 1'b0;
    m_state = 4'd0;
    check("rst_state", tap_state, 4'd0);
    check("rst_ir", ir_out, 4'hF);
    check("rst_tdo_en", TDO_EN, 1'b0);
    check("rst_tdo", TDO, 1'b0);
    check("rst_enables", {clockdr, updatedr, shiftdr, clockdr_is, updatedr_is, shiftdr_is, extest}, 7'd0);
  endtask

  // From RTI: load an opcode LSB first, return to RTI.
  task automatic load_ir(input logic [3:0] op);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{tag: "ir_tdo", exp: (i == 0)});
      step(i == 3, op[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("ir_out", ir_out, op);
  endtask

  // From RTI: capture, n shifts, update. src 0=BSR, 1=ISR, 2=bypass.
  task automatic dr_scan(input int n, input int src, input logic [31:0] tdi_pat);
    logic byp_m;
    logic bsr_bit, tdi_bit;
    byp_m = 1'b0;
    clear_counts();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      bsr_bit = 1'($urandom_range(0, 1));
      TDO_BSR = bsr_bit;
      TDO_ISR = ~bsr_bit;
      tdi_bit = (i < 32) ? tdi_pat[i] : 1'($urandom_range(0, 1));
      case (src)
        0:       sb_q.push_back('{tag: "bsr_tdo", exp: bsr_bit});
        1:       sb_q.push_back('{tag: "isr_tdo", exp: ~bsr_bit});
        default: sb_q.push_back('{tag: "byp_tdo", exp: byp_m});
      endcase
      byp_m = tdi_bit;
      step(i == n - 1, tdi_bit);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    TMS = 1'b0; TDI = 1'b0; TDO_BSR = 1'b0; TDO_ISR = 1'b0;
    m_state = 4'd0;
    clear_counts();
    do_reset();

    // EXTEST load and BSR scan
    step(1'b0, 1'b0);
    load_ir(4'b0000);
    check("extest_on", extest, 1'b1);
    dr_scan(74, 0, 32'h0);
    check("bsr_clockdr_cnt", c_ck, 75);
    check("bsr_shiftdr_cnt", c_sh, 74);
    check("bsr_updatedr_cnt", c_up, 1);
    check("bsr_is_cnt", c_ck_is + c_sh_is + c_up_is, 0);

    // Undefined opcode behaves as bypass
    load_ir(4'b0110);
    check("extest_off_byp", extest, 1'b0);
    dr_scan(4, 2, 32'b1101);
    check("byp_clockdr_cnt", c_ck + c_sh + c_up, 0);
    check("byp_clockdr_is_cnt", c_ck_is + c_sh_is + c_up_is, 0);

    // INTSCAN routing
    load_ir(4'b0010);
    check("extest_off_isr", extest, 1'b0);
    dr_scan(10, 1, 32'h2A5);
    check("isr_clockdr_is_cnt", c_ck_is, 11);
    check("isr_shiftdr_is_cnt", c_sh_is, 10);
    check("isr_updatedr_is_cnt", c_up_is, 1);
    check("isr_bsr_cnt", c_ck + c_sh + c_up, 0);

    // Five TMS=1 from SH_DR reach TLR and restore BYPASS
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms_tlr_state", tap_state, 4'd0);
    check("tms_tlr_ir", ir_out, 4'hF);

    // Reset after two IR bits: no partial instruction update
    step(1'b0, 1'b0);
    load_ir(4'b0000);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    do_reset();

    // SAMPLE, then hold PA_DR for three cycles
    step(1'b0, 1'b0);
    load_ir(4'b0001);
    check("extest_off_sample", extest, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    clear_counts();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check("pause_enables", c_ck + c_sh + c_up + c_ck_is + c_sh_is + c_up_is, 0);
    check("pause_tdo_en", c_en, 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("pause_exit_state", tap_state, 4'd1);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
